efuse_seq_ctrl: RTL and testbench

Sequencer that sits directly upstream of the eFuse AEN generator. It issues refresh/pgmen/rden/addr requests in register mode and waits for `efuse_aen_done`. On reads it captures macro data into a shadow-register write port. Supports two operations: a full autoload read of addresses 0..NUM_ADDR-1 and a single-address program.

---
 rtl/efuse_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_efuse_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_seq_ctrl.sv
// eFuse access sequencer: drives the AEN generator in register mode for an autoload read
// sweep or a single-address program, and forwards read data to a shadow write port.
module efuse_seq_ctrl #(
    parameter int unsigned NUM_ADDR    = 32,
    parameter int unsigned TIMEOUT_CYC = 2048
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       seq_start_rd,
    input  logic       seq_start_pgm,
    input  logic [7:0] seq_pgm_addr,
    input  logic       efuse_aen_done,
    input  logic [7:0] efuse_dout,
    output logic       efuse_reg_mode,
    output logic       efuse_refresh,
    output logic       efuse_pgmen,
    output logic       efuse_rden,
    output logic [7:0] efuse_addr,
    output logic       shadow_we,
    output logic [7:0] shadow_addr,
    output logic [7:0] shadow_wdata,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       seq_err
);

    localparam logic [7:0]  LastAddr = 8'(NUM_ADDR - 1);
    localparam logic [11:0] TmoLast  = 12'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StIssue,
        StGuard,
        StWait,
        StCapture,
        StFinish
    } state_e;

    state_e      state_q, state_d;
    logic        op_rd_q, op_rd_d;
    logic [7:0]  addr_q, addr_d;
    logic [11:0] tmo_q, tmo_d;
    logic        guard_q, guard_d;
    logic [7:0]  data_q, data_d;
    logic        err_q, err_d;

    logic        reg_mode_q, reg_mode_d;
    logic        refresh_q, refresh_d;
    logic        pgmen_q, pgmen_d;
    logic        rden_q, rden_d;
    logic [7:0]  efuse_addr_q, efuse_addr_d;
    logic        shadow_we_q, shadow_we_d;
    logic [7:0]  shadow_addr_q, shadow_addr_d;
    logic [7:0]  shadow_wdata_q, shadow_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_comb begin
        state_d = state_q;
        op_rd_d = op_rd_q;
        addr_d  = addr_q;
        tmo_d   = tmo_q;
        guard_d = guard_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (seq_start_rd || seq_start_pgm) begin
                    op_rd_d = seq_start_rd;
                    addr_d  = seq_start_rd ? 8'd0 : seq_pgm_addr;
                    err_d   = 1'b0;
                    state_d = StClr;
                end
            end
            StClr: state_d = StIssue;
            StIssue: begin
                guard_d = 1'b0;
                tmo_d   = 12'd0;
                state_d = StGuard;
            end
            // Done is ignored here so a stale flag from the previous pulse is never taken.
            StGuard: begin
                guard_d = 1'b1;
                if (guard_q) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                tmo_d = tmo_q + 12'd1;
                if (efuse_aen_done) begin
                    data_d  = efuse_dout;
                    state_d = op_rd_q ? StCapture : StFinish;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end
            end
            StCapture: begin
                if (addr_q == LastAddr) begin
                    state_d = StFinish;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = StIssue;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so every output is a flop.
        reg_mode_d     = state_d inside {StClr, StIssue, StGuard, StWait, StCapture};
        refresh_d      = state_d inside {StClr, StIssue};
        rden_d         = op_rd_d && (state_d inside {StIssue, StGuard, StWait});
        pgmen_d        = !op_rd_d && (state_d inside {StIssue, StGuard, StWait});
        efuse_addr_d   = (state_d == StIssue) ? addr_d : efuse_addr_q;
        shadow_we_d    = (state_d == StCapture);
        shadow_addr_d  = shadow_we_d ? addr_d : shadow_addr_q;
        shadow_wdata_d = shadow_we_d ? data_d : shadow_wdata_q;
        busy_d         = (state_d != StIdle);
        done_d         = (state_d == StFinish);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            op_rd_q        <= 1'b0;
            addr_q         <= 8'd0;
            tmo_q          <= 12'd0;
            guard_q        <= 1'b0;
            data_q         <= 8'd0;
            err_q          <= 1'b0;
            reg_mode_q     <= 1'b0;
            refresh_q      <= 1'b0;
            pgmen_q        <= 1'b0;
            rden_q         <= 1'b0;
            efuse_addr_q   <= 8'd0;
            shadow_we_q    <= 1'b0;
            shadow_addr_q  <= 8'd0;
            shadow_wdata_q <= 8'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_rd_q        <= op_rd_d;
            addr_q         <= addr_d;
            tmo_q          <= tmo_d;
            guard_q        <= guard_d;
            data_q         <= data_d;
            err_q          <= err_d;
            reg_mode_q     <= reg_mode_d;
            refresh_q      <= refresh_d;
            pgmen_q        <= pgmen_d;
            rden_q         <= rden_d;
            efuse_addr_q   <= efuse_addr_d;
            shadow_we_q    <= shadow_we_d;
            shadow_addr_q  <= shadow_addr_d;
            shadow_wdata_q <= shadow_wdata_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign efuse_reg_mode = reg_mode_q;
    assign efuse_refresh  = refresh_q;
    assign efuse_pgmen    = pgmen_q;
    assign efuse_rden     = rden_q;
    assign efuse_addr     = efuse_addr_q;
    assign shadow_we      = shadow_we_q;
    assign shadow_addr    = shadow_addr_q;
    assign shadow_wdata   = shadow_wdata_q;
    assign seq_busy       = busy_q;
    assign seq_done       = done_q;
    assign seq_err        = err_q;

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Bench for efuse_seq_ctrl: an AEN generator model plus vector table, hand sequences and
// randomized operations checked against arithmetic expectations.
module tb_efuse_seq_ctrl;

    localparam int NA = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seq_start_rd = 1'b0;
    logic       seq_start_pgm = 1'b0;
    logic [7:0] seq_pgm_addr = 8'd0;
    logic       efuse_aen_done;
    logic [7:0] efuse_dout;
    logic       efuse_reg_mode, efuse_refresh, efuse_pgmen, efuse_rden;
    logic [7:0] efuse_addr;
    logic       shadow_we;
    logic [7:0] shadow_addr, shadow_wdata;
    logic       seq_busy, seq_done, seq_err;

    int total = 0;
    int bad = 0;

    efuse_seq_ctrl #(
        .NUM_ADDR    (NA),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .seq_start_rd   (seq_start_rd),
        .seq_start_pgm  (seq_start_pgm),
        .seq_pgm_addr   (seq_pgm_addr),
        .efuse_aen_done (efuse_aen_done),
        .efuse_dout     (efuse_dout),
        .efuse_reg_mode (efuse_reg_mode),
        .efuse_refresh  (efuse_refresh),
        .efuse_pgmen    (efuse_pgmen),
        .efuse_rden     (efuse_rden),
        .efuse_addr     (efuse_addr),
        .shadow_we      (shadow_we),
        .shadow_addr    (shadow_addr),
        .shadow_wdata   (shadow_wdata),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .seq_err        (seq_err)
    );

    always #5 clk = ~clk;

    // AEN generator model: fires only when the requested address differs from the stored
    // one; a refresh with no enable clears the stored address. Done lands on WAIT cycle tpgm.
    int        tpgm = 5;
    bit        done_en = 1'b1;
    logic [8:0] prev_addr;
    int        gcnt;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_addr <= 9'h100;
            gcnt      <= 0;
        end else if (efuse_refresh && !efuse_rden && !efuse_pgmen) begin
            prev_addr <= 9'h100;
            if (gcnt != 0) gcnt <= gcnt - 1;
        end else if (efuse_refresh && (efuse_rden || efuse_pgmen) &&
                     ({1'b0, efuse_addr} != prev_addr)) begin
            prev_addr <= {1'b0, efuse_addr};
            gcnt      <= tpgm + 3;
        end else if (gcnt != 0) begin
            gcnt <= gcnt - 1;
        end
    end

    assign efuse_aen_done = done_en && (gcnt == 1);
    assign efuse_dout     = efuse_addr ^ 8'hA5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {efuse_reg_mode, efuse_refresh, efuse_pgmen, efuse_rden, efuse_addr, shadow_we,
                shadow_addr, shadow_wdata, seq_busy, seq_done, seq_err};
    endfunction

    // Runs one operation and checks latency (start cycle to seq_done), shadow writes,
    // enable-active cycles, error flag and per-cycle protocol rules.
    task automatic run_op(input string name, input bit rd, input bit both, input bit spam,
                          input logic [7:0] pa, input int tp, input bit den, input int exp_lat,
                          input int exp_nw, input bit exp_err, input int exp_en);
        int  lat;
        int  nw;
        int  en;
        int  viol;
        bit  seen;
        bit  eff_rd;
        eff_rd  = rd || both;
        tpgm    = tp;
        done_en = den;
        @(posedge clk); #1;
        seq_start_rd  = rd;
        seq_start_pgm = !rd || both;
        seq_pgm_addr  = pa;
        @(posedge clk); #1;
        seq_start_rd  = 1'b0;
        seq_start_pgm = 1'b0;
        chk({name, " clr"}, {26'd0, seq_busy, efuse_refresh, efuse_rden, efuse_pgmen,
                             efuse_reg_mode, seq_err}, 32'b110010);
        lat = 1; nw = 0; en = 0; viol = 0; seen = 1'b0;
        while (!seen && lat < 400) begin
            if (efuse_rden && efuse_pgmen) viol++;
            if (shadow_we && efuse_refresh) viol++;
            if (eff_rd && efuse_pgmen) viol++;
            if (!eff_rd && (efuse_rden || shadow_we)) viol++;
            if (!eff_rd && efuse_pgmen && efuse_addr != pa) viol++;
            if (eff_rd && efuse_rden && efuse_addr != 8'(nw)) viol++;
            if (efuse_rden || efuse_pgmen) en++;
            if (shadow_we) begin
                chk({name, " waddr"}, {24'd0, shadow_addr}, 32'(nw));
                chk({name, " wdata"}, {24'd0, shadow_wdata}, 32'(8'(nw) ^ 8'hA5));
                nw++;
            end
            if (seq_done) begin
                seen = 1'b1;
                seq_start_rd  = 1'b0;
                seq_start_pgm = 1'b0;
            end else begin
                if (spam) begin
                    seq_start_rd  = 1'($urandom_range(0, 1));
                    seq_start_pgm = 1'($urandom_range(0, 1));
                    seq_pgm_addr  = 8'($urandom);
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({name, " latency"}, 32'(lat), 32'(exp_lat));
        chk({name, " writes"}, 32'(nw), 32'(exp_nw));
        chk({name, " en cycles"}, 32'(en), 32'(exp_en));
        chk({name, " rules"}, 32'(viol), 32'd0);
        chk({name, " fin"}, {29'd0, efuse_reg_mode, seq_busy, seq_err}, {29'd0, 1'b0, 1'b1, exp_err});
        @(posedge clk); #1;
        chk({name, " idle"}, {29'd0, seq_busy, seq_done, seq_err}, {29'd0, 1'b0, 1'b0, exp_err});
    endtask

    typedef struct {
        string      name;
        bit         rd;
        bit         both;
        bit         spam;
        logic [7:0] pa;
        int         tp;
        bit         den;
        int         lat;
        int         nw;
        bit         err;
        int         en;
    } vec_t;

    initial begin
        vec_t vecs[9];
        bit   found;
        int   dviol;

        vecs[0] = '{"rd4 tp5",     1, 0, 0, 8'h00,  5, 1, 38, 4, 0, 32};
        vecs[1] = '{"pgm17 a",     0, 0, 0, 8'h17,  3, 1,  8, 0, 0,  6};
        vecs[2] = '{"pgm17 b",     0, 0, 0, 8'h17,  3, 1,  8, 0, 0,  6};
        vecs[3] = '{"pgm tmo",     0, 0, 0, 8'h00,  5, 0, 21, 0, 1, 19};
        vecs[4] = '{"rd both spam", 1, 1, 1, 8'h33,  1, 1, 22, 4, 0, 16};
        vecs[5] = '{"pgm tie",     0, 0, 0, 8'h42, 16, 1, 21, 0, 0, 19};
        vecs[6] = '{"pgm late",    0, 0, 0, 8'hFF, 17, 1, 21, 0, 1, 19};
        vecs[7] = '{"rd tmo",      1, 0, 0, 8'h00,  5, 0, 21, 0, 1, 19};
        vecs[8] = '{"rd tp2",      1, 0, 1, 8'h00,  2, 1, 26, 4, 0, 20};

        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("reset outs", all_outs(), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post reset idle", all_outs(), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].name, vecs[i].rd, vecs[i].both, vecs[i].spam, vecs[i].pa, vecs[i].tp,
                   vecs[i].den, vecs[i].lat, vecs[i].nw, vecs[i].err, vecs[i].en);
        end

        // Reset in the middle of WAIT for address 2.
        tpgm = 8; done_en = 1'b1;
        @(posedge clk); #1 seq_start_rd = 1'b1;
        @(posedge clk); #1 seq_start_rd = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (efuse_refresh && efuse_rden && efuse_addr == 8'd2) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("rst reach addr2", 32'(found), 32'd1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst async outs", all_outs(), 32'd0);
        dviol = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (all_outs() != 32'd0) dviol++;
        end
        chk("rst held quiet", 32'(dviol), 32'd0);
        rst_n = 1'b1;
        run_op("rd after rst", 1, 0, 0, 8'h00, 5, 1, 38, 4, 0, 32);

        // Randomized operations against an arithmetic model of the sequencer.
        for (int k = 0; k < 25; k++) begin
            bit         rd;
            bit         den;
            int         tp;
            logic [7:0] pa;
            bit         ok;
            int         w;
            int         lat;
            int         nw;
            int         en;
            rd  = 1'($urandom_range(0, 1));
            den = ($urandom_range(0, 9) != 0);
            tp  = int'($urandom_range(1, 18));
            pa  = 8'($urandom);
            ok  = den && (tp <= TO);
            w   = ok ? tp : TO;
            if (rd && ok) begin
                lat = 2 + NA * (4 + tp);
                nw  = NA;
                en  = NA * (3 + tp);
            end else begin
                lat = 5 + w;
                nw  = 0;
                en  = 3 + w;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op("rand", rd, 0, 1'($urandom_range(0, 1)), pa, tp, den, lat, nw, !ok, en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
